// File: rtl/wb_port_arbiter_pkg.sv
// Shared register-file bus definitions and the arbiter's state/grant types.
// Imported by the writeback-port interface, the result FIFO and the arbiter top.
package wb_port_arbiter_pkg;

  localparam int REG_BUS_W      = 32;
  localparam int REG_ADDR_BUS_W = 5;
  localparam int REG_NUM        = 32;

  localparam logic [REG_BUS_W-1:0] ZERO_WORD    = '0;
  localparam logic                 WRITE_ENABLE = 1'b1;
  localparam logic                 RST_ENABLE   = 1'b1;

  // Starvation counter must hold STARVE_MAX-1 for STARVE_MAX up to 255.
  localparam int STARVE_CNT_W = 8;

  typedef enum logic {
    ST_RUN,
    ST_FORCE
  } starve_state_e;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_PIPE,
    GNT_FIFO
  } grant_e;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bundle of pipeline, mul/div, decode and register-file signals around the
// writeback-port arbiter; the arbiter sits on the slave modport.
interface wb_port_arbiter_if
  import wb_port_arbiter_pkg::*;
#(
  parameter int DATA_W = REG_BUS_W,
  parameter int ADDR_W = REG_ADDR_BUS_W
);

  logic              pipe_wr_en;
  logic [ADDR_W-1:0] pipe_wr_addr;
  logic [DATA_W-1:0] pipe_wr_data;
  logic              pipe_hold;

  logic              mc_issue;
  logic [ADDR_W-1:0] mc_issue_addr;
  logic              mc_valid;
  logic [ADDR_W-1:0] mc_addr;
  logic [DATA_W-1:0] mc_data;
  logic              mc_ready;

  logic              dec_rd_en1;
  logic [ADDR_W-1:0] dec_rd_addr1;
  logic              dec_rd_en2;
  logic [ADDR_W-1:0] dec_rd_addr2;
  logic              dec_wr_en;
  logic [ADDR_W-1:0] dec_wr_addr;
  logic              dec_stall;

  logic              rf_wr_en;
  logic [ADDR_W-1:0] rf_wr_addr;
  logic [DATA_W-1:0] rf_wr_data;

  modport slave (
    input  pipe_wr_en, pipe_wr_addr, pipe_wr_data,
    output pipe_hold,
    input  mc_issue, mc_issue_addr, mc_valid, mc_addr, mc_data,
    output mc_ready,
    input  dec_rd_en1, dec_rd_addr1, dec_rd_en2, dec_rd_addr2, dec_wr_en, dec_wr_addr,
    output dec_stall,
    output rf_wr_en, rf_wr_addr, rf_wr_data
  );

  modport master (
    output pipe_wr_en, pipe_wr_addr, pipe_wr_data,
    input  pipe_hold,
    output mc_issue, mc_issue_addr, mc_valid, mc_addr, mc_data,
    input  mc_ready,
    output dec_rd_en1, dec_rd_addr1, dec_rd_en2, dec_rd_addr2, dec_wr_en, dec_wr_addr,
    input  dec_stall,
    input  rf_wr_en, rf_wr_addr, rf_wr_data
  );

endinterface

// File: rtl/wb_fifo2.sv
// Two-entry FIFO holding {addr, data} results from the multi-cycle unit.
// Callers guarantee no push when full and no pop when empty.
module wb_fifo2
  import wb_port_arbiter_pkg::*;
#(
  parameter int DATA_W = REG_BUS_W,
  parameter int ADDR_W = REG_ADDR_BUS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [ADDR_W-1:0] head_addr,
  output logic [1:0]        count,
  output logic              empty
);

  logic [DATA_W-1:0] data_mem_q [2];
  logic [ADDR_W-1:0] addr_mem_q [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q,  count_d;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count/pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem_q[wr_ptr_q] <= push_data;
      addr_mem_q[wr_ptr_q] <= push_addr;
    end
  end

  assign head_data = data_mem_q[rd_ptr_q];
  assign head_addr = addr_mem_q[rd_ptr_q];
  assign count     = count_q;
  assign empty     = (count_q == 2'd0);

endmodule

// File: rtl/wb_port_arbiter.sv
// Owns the register-file write port: shares it between pipeline writeback and
// buffered mul/div results, tracks outstanding M destinations, forces drains.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DATA_W     = REG_BUS_W,
  parameter int ADDR_W     = REG_ADDR_BUS_W,
  parameter int NREG       = REG_NUM,
  parameter int STARVE_MAX = 8
) (
  input  logic               clk,
  input  logic               rst,
  wb_port_arbiter_if.slave   bus
);

  logic              fifo_empty;
  logic [1:0]        fifo_count;
  logic [DATA_W-1:0] head_data;
  logic [ADDR_W-1:0] head_addr;

  logic              p_eff;
  logic              push;
  logic              pop;
  logic              mc_ready;
  logic              dec_stall;
  logic              issue_set;
  grant_e            grant;

  logic              rf_wr_en;
  logic [ADDR_W-1:0] rf_wr_addr;
  logic [DATA_W-1:0] rf_wr_data;

  starve_state_e             state_q, state_d;
  logic [STARVE_CNT_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic [NREG-1:0]           busy_q, busy_d;

  wb_fifo2 #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (bus.mc_data),
    .push_addr (bus.mc_addr),
    .pop       (pop),
    .head_data (head_data),
    .head_addr (head_addr),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  // A forced drain outranks the pipeline; a pipe write to r0 is no request.
  always_comb begin
    p_eff = bus.pipe_wr_en && (bus.pipe_wr_addr != '0);
    grant = GNT_NONE;
    if (rst != RST_ENABLE) begin
      if (state_q == ST_FORCE)  grant = GNT_FIFO;
      else if (p_eff)           grant = GNT_PIPE;
      else if (!fifo_empty)     grant = GNT_FIFO;
    end
  end

  assign pop      = (grant == GNT_FIFO);
  assign mc_ready = (fifo_count != 2'd2) && (rst != RST_ENABLE);
  assign push     = bus.mc_valid && mc_ready;

  always_comb begin
    rf_wr_en   = 1'b0;
    rf_wr_addr = '0;
    rf_wr_data = '0;
    case (grant)
      GNT_PIPE: begin
        rf_wr_en   = WRITE_ENABLE;
        rf_wr_addr = bus.pipe_wr_addr;
        rf_wr_data = bus.pipe_wr_data;
      end
      GNT_FIFO: begin
        rf_wr_en   = WRITE_ENABLE;
        rf_wr_addr = head_addr;
        rf_wr_data = head_data;
      end
      default: ;
    endcase
  end

  // No FIFO-to-decode bypass: readers wait until the result reaches the register file.
  always_comb begin
    dec_stall = 1'b0;
    if (rst != RST_ENABLE) begin
      dec_stall = (bus.dec_rd_en1 && busy_q[bus.dec_rd_addr1])
               || (bus.dec_rd_en2 && busy_q[bus.dec_rd_addr2])
               || (bus.dec_wr_en  && busy_q[bus.dec_wr_addr])
               || (bus.mc_issue && (fifo_count == 2'd2) && bus.mc_valid);
    end
  end

  assign issue_set = bus.mc_issue && !dec_stall && (bus.mc_issue_addr != '0);

  // Clear on pop first so a same-cycle issue to the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (pop)       busy_d[head_addr]         = 1'b0;
    if (issue_set) busy_d[bus.mc_issue_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (fifo_empty || pop) begin
          starve_cnt_d = '0;
        end else if (starve_cnt_q == STARVE_CNT_W'(STARVE_MAX - 1)) begin
          state_d      = ST_FORCE;
          starve_cnt_d = '0;
        end else begin
          starve_cnt_d = starve_cnt_q + STARVE_CNT_W'(1);
        end
      end
      ST_FORCE: begin
        state_d      = ST_RUN;
        starve_cnt_d = '0;
      end
      default: begin
        state_d      = ST_RUN;
        starve_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q      <= ST_RUN;
      starve_cnt_q <= '0;
      busy_q       <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.pipe_hold  = (state_q == ST_FORCE);
  assign bus.mc_ready   = mc_ready;
  assign bus.dec_stall  = dec_stall;
  assign bus.rf_wr_en   = rf_wr_en;
  assign bus.rf_wr_addr = rf_wr_addr;
  assign bus.rf_wr_data = rf_wr_data;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed vector table, hand-written corner
// sequences, then constrained-random traffic against a queue-based model.
module tb_wb_port_arbiter;

  localparam int STARVE = 8;

  typedef struct {
    logic        rst;
    logic        p_en;
    logic [4:0]  p_addr;
    logic [31:0] p_data;
    logic        mv;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic        issue;
    logic [4:0]  i_addr;
    logic        rd1;
    logic [4:0]  a1;
    logic        rd2;
    logic [4:0]  a2;
    logic        wr;
    logic [4:0]  wa;
  } stim_t;

  typedef struct {
    logic        wr_en;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        ready;
    logic        stall;
    logic        hold;
    logic        fifo_gnt;
  } out_t;

  typedef struct {
    stim_t s;
    out_t  e;
  } vec_t;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  // Reference model state: queue of pending results, busy set, denied-cycle run.
  ent_t mq[$];
  bit   mbusy[32];
  int   mdenied;
  bit   mhold;

  vec_t tbl[$];

  wb_port_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  wb_port_arbiter #(
    .DATA_W     (32),
    .ADDR_W     (5),
    .NREG       (32),
    .STARVE_MAX (STARVE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic out_t mk_out(logic en, logic [4:0] a, logic [31:0] d,
                                  logic rdy, logic stl, logic hld);
    out_t o;
    o = '{default: '0};
    o.wr_en = en; o.addr = a; o.data = d;
    o.ready = rdy; o.stall = stl; o.hold = hld;
    return o;
  endfunction

  task automatic drive(input stim_t s);
    rst               = s.rst;
    bus.pipe_wr_en    = s.p_en;
    bus.pipe_wr_addr  = s.p_addr;
    bus.pipe_wr_data  = s.p_data;
    bus.mc_valid      = s.mv;
    bus.mc_addr       = s.m_addr;
    bus.mc_data       = s.m_data;
    bus.mc_issue      = s.issue;
    bus.mc_issue_addr = s.i_addr;
    bus.dec_rd_en1    = s.rd1;
    bus.dec_rd_addr1  = s.a1;
    bus.dec_rd_en2    = s.rd2;
    bus.dec_rd_addr2  = s.a2;
    bus.dec_wr_en     = s.wr;
    bus.dec_wr_addr   = s.wa;
  endtask

  function automatic out_t sample();
    out_t o;
    o = '{default: '0};
    o.wr_en = bus.rf_wr_en;  o.addr  = bus.rf_wr_addr; o.data = bus.rf_wr_data;
    o.ready = bus.mc_ready;  o.stall = bus.dec_stall;  o.hold = bus.pipe_hold;
    return o;
  endfunction

  function automatic out_t model_eval(stim_t s);
    out_t o;
    int   n;
    bit   p_eff;
    o = '{default: '0};
    n = mq.size();
    p_eff = s.p_en && (s.p_addr != 0);
    o.hold = mhold;
    if (s.rst) return o;
    o.ready = (n < 2);
    o.stall = (s.rd1 && mbusy[s.a1]) || (s.rd2 && mbusy[s.a2]) ||
              (s.wr && mbusy[s.wa]) || (s.issue && n == 2 && s.mv);
    if (n > 0 && (mhold || !p_eff)) begin
      o.wr_en = 1'b1; o.addr = mq[0].addr; o.data = mq[0].data; o.fifo_gnt = 1'b1;
    end else if (p_eff) begin
      o.wr_en = 1'b1; o.addr = s.p_addr; o.data = s.p_data;
    end
    return o;
  endfunction

  task automatic model_edge(input stim_t s, input out_t e);
    int   n;
    ent_t h;
    n = mq.size();
    if (s.rst) begin
      mq.delete();
      foreach (mbusy[i]) mbusy[i] = 1'b0;
      mdenied = 0;
      mhold   = 1'b0;
      return;
    end
    if (e.fifo_gnt) begin
      h = mq.pop_front();
      mbusy[h.addr] = 1'b0;
    end
    if (s.mv && n < 2) mq.push_back({s.m_addr, s.m_data});
    if (s.issue && !e.stall && s.i_addr != 0) mbusy[s.i_addr] = 1'b1;
    if (mhold) begin
      mhold = 1'b0;
      mdenied = 0;
    end else if (n > 0 && !e.fifo_gnt) begin
      mdenied++;
      if (mdenied == STARVE) begin
        mhold = 1'b1;
        mdenied = 0;
      end
    end else begin
      mdenied = 0;
    end
  endtask

  // One clock: drive, sample mid-cycle, advance the model, cross the edge.
  task automatic step(input stim_t s, output out_t got, output out_t exp);
    drive(s);
    @(negedge clk);
    exp = model_eval(s);
    got = sample();
    model_edge(s, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic compare_out(input string tag, input out_t got, input out_t exp);
    check({tag, "_wr_en"}, 64'(got.wr_en), 64'(exp.wr_en));
    check({tag, "_ready"}, 64'(got.ready), 64'(exp.ready));
    check({tag, "_stall"}, 64'(got.stall), 64'(exp.stall));
    check({tag, "_hold"},  64'(got.hold),  64'(exp.hold));
    if (exp.wr_en) begin
      check({tag, "_addr"}, 64'(got.addr), 64'(exp.addr));
      check({tag, "_data"}, 64'(got.data), 64'(exp.data));
    end
  endtask

  task automatic add_vec(input stim_t s, input out_t e);
    vec_t v;
    v.s = s;
    v.e = e;
    tbl.push_back(v);
  endtask

  task automatic reset_cycle();
    stim_t s;
    out_t  got, exp;
    s = idle();
    s.rst = 1'b1;
    step(s, got, exp);
  endtask

  initial begin
    stim_t s, prev;
    out_t  got, exp, prev_exp;

    // ---------------- directed vector table ----------------
    s = idle(); s.rst = 1;                                   add_vec(s, mk_out(0, 0, 0, 0, 0, 0));
    s = idle();                                              add_vec(s, mk_out(0, 0, 0, 1, 0, 0));
    s = idle(); s.issue = 1; s.i_addr = 3;                   add_vec(s, mk_out(0, 0, 0, 1, 0, 0));
    s = idle(); s.mv = 1; s.m_addr = 3; s.m_data = 32'hDEADBEEF; s.rd1 = 1; s.a1 = 3;
                                                             add_vec(s, mk_out(0, 0, 0, 1, 1, 0));
    s = idle(); s.rd1 = 1; s.a1 = 3;                         add_vec(s, mk_out(1, 3, 32'hDEADBEEF, 1, 1, 0));
    s = idle(); s.rd1 = 1; s.a1 = 3;                         add_vec(s, mk_out(0, 0, 0, 1, 0, 0));
    s = idle(); s.issue = 1; s.i_addr = 0; s.mv = 1; s.m_addr = 6; s.m_data = 32'h66;
                                                             add_vec(s, mk_out(0, 0, 0, 1, 0, 0));
    s = idle(); s.p_en = 1; s.p_addr = 0; s.p_data = 32'h77; s.rd1 = 1; s.a1 = 0; s.wr = 1; s.wa = 0;
                                                             add_vec(s, mk_out(1, 6, 32'h66, 1, 0, 0));
    s = idle();                                              add_vec(s, mk_out(0, 0, 0, 1, 0, 0));
    s = idle(); s.p_en = 1; s.p_addr = 7; s.p_data = 32'h11; add_vec(s, mk_out(1, 7, 32'h11, 1, 0, 0));
    s = idle(); s.issue = 1; s.i_addr = 10;                  add_vec(s, mk_out(0, 0, 0, 1, 0, 0));
    s = idle(); s.wr = 1; s.wa = 10; s.issue = 1; s.i_addr = 12;
                                                             add_vec(s, mk_out(0, 0, 0, 1, 1, 0));
    s = idle(); s.rd1 = 1; s.a1 = 12;                        add_vec(s, mk_out(0, 0, 0, 1, 0, 0));
    s = idle(); s.rd2 = 1; s.a2 = 10;                        add_vec(s, mk_out(0, 0, 0, 1, 1, 0));

    reset_cycle();
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].s, got, exp);
      compare_out($sformatf("vec%0d", i), got, tbl[i].e);
    end

    // ---------------- collision and forced drain ----------------
    reset_cycle();
    for (int c = 0; c <= 10; c++) begin
      s = idle(); s.p_en = 1; s.p_addr = 7; s.p_data = 32'h11;
      if (c == 0) begin s.mv = 1; s.m_addr = 9; s.m_data = 32'h22; end
      step(s, got, exp);
      check($sformatf("starve_c%0d_hold", c), 64'(got.hold), 64'(c == 9));
      check($sformatf("starve_c%0d_en", c), 64'(got.wr_en), 64'd1);
      check($sformatf("starve_c%0d_addr", c), 64'(got.addr), (c == 9) ? 64'd9 : 64'd7);
      check($sformatf("starve_c%0d_data", c), 64'(got.data), (c == 9) ? 64'h22 : 64'h11);
    end

    // ---------------- full FIFO, then reset mid-traffic ----------------
    for (int c = 0; c <= 5; c++) begin
      s = idle();
      if (c <= 3) begin s.p_en = 1; s.p_addr = 7; s.p_data = 32'h11; end
      case (c)
        0: begin s.mv = 1; s.m_addr = 1; s.m_data = 32'hA1; s.issue = 1; s.i_addr = 5; end
        1: begin s.mv = 1; s.m_addr = 2; s.m_data = 32'hA2; end
        2, 3: begin s.mv = 1; s.m_addr = 3; s.m_data = 32'hA3; s.issue = 1; s.i_addr = 20; end
        4: begin s.rst = 1; s.mv = 1; s.m_addr = 3; s.m_data = 32'hA3; s.issue = 1; s.i_addr = 20;
                 s.rd1 = 1; s.a1 = 5; end
        default: begin s.rd1 = 1; s.a1 = 5; s.wr = 1; s.wa = 20; end
      endcase
      step(s, got, exp);
      case (c)
        0, 1: begin
          check($sformatf("full_c%0d_ready", c), 64'(got.ready), 64'd1);
          check($sformatf("full_c%0d_stall", c), 64'(got.stall), 64'd0);
        end
        2, 3: begin
          check($sformatf("full_c%0d_ready", c), 64'(got.ready), 64'd0);
          check($sformatf("full_c%0d_stall", c), 64'(got.stall), 64'd1);
          check($sformatf("full_c%0d_addr", c), 64'(got.addr), 64'd7);
        end
        4: begin
          check("rst_en", 64'(got.wr_en), 64'd0);
          check("rst_ready", 64'(got.ready), 64'd0);
          check("rst_stall", 64'(got.stall), 64'd0);
        end
        default: begin
          check("post_rst_en", 64'(got.wr_en), 64'd0);
          check("post_rst_ready", 64'(got.ready), 64'd1);
          check("post_rst_stall", 64'(got.stall), 64'd0);
          check("post_rst_hold", 64'(got.hold), 64'd0);
        end
      endcase
    end

    // ---------------- RAW stall on r4 ----------------
    for (int c = 0; c <= 3; c++) begin
      s = idle();
      if (c == 0) begin s.issue = 1; s.i_addr = 4; end
      else begin s.rd1 = 1; s.a1 = 4; end
      if (c == 1) begin s.mv = 1; s.m_addr = 4; s.m_data = 32'h44; end
      step(s, got, exp);
      if (c >= 1) check($sformatf("raw_c%0d_stall", c), 64'(got.stall), 64'(c <= 2));
      if (c == 2) begin
        check("raw_drain_en", 64'(got.wr_en), 64'd1);
        check("raw_drain_addr", 64'(got.addr), 64'd4);
        check("raw_drain_data", 64'(got.data), 64'h44);
      end
    end

    // ---------------- constrained random vs model ----------------
    reset_cycle();
    prev = idle();
    prev_exp = '{default: '0};
    for (int i = 0; i < 1500; i++) begin
      s = idle();
      s.rst = ($urandom_range(0, 99) == 0);
      if (prev_exp.hold && !prev.rst) begin
        s.p_en = prev.p_en; s.p_addr = prev.p_addr; s.p_data = prev.p_data;
      end else begin
        s.p_en   = ($urandom_range(0, 99) < 85);
        s.p_addr = 5'($urandom_range(0, 31));
        s.p_data = $urandom;
      end
      if (prev.mv && !prev_exp.ready && !prev.rst) begin
        s.mv = 1; s.m_addr = prev.m_addr; s.m_data = prev.m_data;
      end else begin
        s.mv     = ($urandom_range(0, 99) < 35);
        s.m_addr = 5'($urandom_range(0, 31));
        s.m_data = $urandom;
      end
      s.issue  = ($urandom_range(0, 99) < 30);
      s.i_addr = 5'($urandom_range(0, 7));
      s.rd1 = 1'($urandom); s.a1 = 5'($urandom_range(0, 7));
      s.rd2 = 1'($urandom); s.a2 = 5'($urandom_range(0, 7));
      s.wr  = 1'($urandom); s.wa = 5'($urandom_range(0, 7));
      step(s, got, exp);
      compare_out($sformatf("rnd%0d", i), got, exp);
      prev = s;
      prev_exp = exp;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
